// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 4-bit CPU control path:
//   - opcode constants (instruction bits [7:4])
//   - bus selector codes driven onto the shared 4-bit bus
//   - ALU operation codes
//   - sequencer state enum
//   - packed load-strobe vector {a, b, rout, out}
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [3:0] OP_NOP    = 4'h0;
   localparam logic [3:0] OP_IN_A   = 4'h1;
   localparam logic [3:0] OP_IN_B   = 4'h2;
   localparam logic [3:0] OP_ADD    = 4'h3;
   localparam logic [3:0] OP_OUT    = 4'h4;
   localparam logic [3:0] OP_MOV_A  = 4'h5;
   localparam logic [3:0] OP_LDC3_A = 4'h6;
   localparam logic [3:0] OP_JMP    = 4'h7;
   localparam logic [3:0] OP_SUB    = 4'h8;
   localparam logic [3:0] OP_JZ     = 4'h9;
   localparam logic [3:0] OP_HLT    = 4'hF;

   localparam logic [2:0] BUS_SW   = 3'b000;
   localparam logic [2:0] BUS_ROUT = 3'b011;
   localparam logic [2:0] BUS_K3   = 3'b101;
   localparam logic [2:0] BUS_NONE = 3'b111;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_WAIT_SW,
      ST_HALTED
   } state_e;

   typedef struct packed {
      logic a;
      logic b;
      logic rout;
      logic out;
   } ld_t;

endpackage

// File: rtl/cpu_decoder.sv
// -----------------------------------------------------------------------------
// cpu_decoder
// Purely combinational opcode decoder. Produces the datapath controls an
// instruction would issue plus classification flags used by the sequencer.
// For IN_A/IN_B the bus/load outputs describe the transfer that happens once
// the switch handshake completes.
// Ports:
//   opcode   in  4  instruction bits [7:4]
//   bus_sel  out 3  bus source code
//   alu_op   out 2  ALU operation
//   ld       out 4  load strobes {a, b, rout, out}, at most one set
//   is_in    out 1  instruction waits for the switch handshake
//   is_jmp   out 1  unconditional jump
//   is_jz    out 1  jump if zero
//   is_hlt   out 1  halt
//   illegal  out 1  undefined opcode
// -----------------------------------------------------------------------------
module cpu_decoder
   import cpu_pkg::*;
(
   input  logic [3:0] opcode,
   output logic [2:0] bus_sel,
   output logic [1:0] alu_op,
   output ld_t        ld,
   output logic       is_in,
   output logic       is_jmp,
   output logic       is_jz,
   output logic       is_hlt,
   output logic       illegal
);

   always_comb begin
      bus_sel = BUS_NONE;
      alu_op  = ALU_ADD;
      ld      = '0;
      is_in   = 1'b0;
      is_jmp  = 1'b0;
      is_jz   = 1'b0;
      is_hlt  = 1'b0;
      illegal = 1'b0;
      case (opcode)
         OP_NOP: ;
         OP_IN_A: begin
            bus_sel = BUS_SW;
            ld.a    = 1'b1;
            is_in   = 1'b1;
         end
         OP_IN_B: begin
            bus_sel = BUS_SW;
            ld.b    = 1'b1;
            is_in   = 1'b1;
         end
         OP_ADD: begin
            alu_op  = ALU_ADD;
            ld.rout = 1'b1;
         end
         OP_SUB: begin
            alu_op  = ALU_SUB;
            ld.rout = 1'b1;
         end
         OP_OUT: begin
            bus_sel = BUS_ROUT;
            ld.out  = 1'b1;
         end
         OP_MOV_A: begin
            bus_sel = BUS_ROUT;
            ld.a    = 1'b1;
         end
         OP_LDC3_A: begin
            bus_sel = BUS_K3;
            ld.a    = 1'b1;
         end
         OP_JMP:  is_jmp  = 1'b1;
         OP_JZ:   is_jz   = 1'b1;
         OP_HLT:  is_hlt  = 1'b1;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/cpu_control_unit.sv
// -----------------------------------------------------------------------------
// cpu_control_unit
// Fetch/decode/execute sequencer for the 4-bit CPU. Reads instructions from a
// synchronous ROM (data one cycle after the address) and issues registered
// control strobes for exactly one cycle after each execute decision.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   run               start request, looked at only while idle
//   imem_addr         ROM address (always equals pc)
//   imem_data         ROM data: [7:4] opcode, [3:0] operand
//   sw_valid, sw_ack  switch-input handshake
//   zero_flag         datapath flag, rout == 0
//   bus_selector      shared bus source (111 = none)
//   alu_op            ALU operation, meaningful with ld_rout
//   ld_a/ld_b/ld_rout/ld_out  register load strobes
//   pc                program counter
//   halted            high once a HLT has executed
//   illegal_op        one-cycle pulse on an undefined opcode
// -----------------------------------------------------------------------------
module cpu_control_unit
   import cpu_pkg::*;
#(
   parameter int                   PC_WIDTH = 4,
   parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic [7:0]          imem_data,
   input  logic                sw_valid,
   output logic                sw_ack,
   input  logic                zero_flag,
   output logic [2:0]          bus_selector,
   output logic [1:0]          alu_op,
   output logic                ld_a,
   output logic                ld_b,
   output logic                ld_rout,
   output logic                ld_out,
   output logic [PC_WIDTH-1:0] pc,
   output logic                halted,
   output logic                illegal_op
);

   state_e              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [7:0]          ir_q, ir_d;
   logic [2:0]          bus_q, bus_d;
   logic [1:0]          alu_q, alu_d;
   ld_t                 ld_q, ld_d;
   logic                sw_ack_q, sw_ack_d;
   logic                illegal_q, illegal_d;

   logic [2:0] dec_bus;
   logic [1:0] dec_alu;
   ld_t        dec_ld;
   logic       dec_is_in, dec_is_jmp, dec_is_jz, dec_is_hlt, dec_illegal;

   logic [PC_WIDTH-1:0] pc_inc;
   logic [PC_WIDTH-1:0] operand;

   cpu_decoder u_decoder (
      .opcode  (ir_q[7:4]),
      .bus_sel (dec_bus),
      .alu_op  (dec_alu),
      .ld      (dec_ld),
      .is_in   (dec_is_in),
      .is_jmp  (dec_is_jmp),
      .is_jz   (dec_is_jz),
      .is_hlt  (dec_is_hlt),
      .illegal (dec_illegal)
   );

   // Natural-width increment wraps the last ROM slot back to address 0.
   assign pc_inc  = pc_q + PC_WIDTH'(1);
   assign operand = PC_WIDTH'(ir_q[3:0]);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      bus_d     = BUS_NONE;
      alu_d     = ALU_ADD;
      ld_d      = '0;
      sw_ack_d  = 1'b0;
      illegal_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            // ROM output now reflects the address presented during FETCH.
            ir_d    = imem_data;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (dec_is_hlt) begin
               state_d = ST_HALTED;
            end else if (dec_is_in) begin
               // The bus transfer is deferred until the switch is valid.
               state_d = ST_WAIT_SW;
            end else begin
               state_d   = ST_FETCH;
               bus_d     = dec_bus;
               alu_d     = dec_alu;
               ld_d      = dec_ld;
               illegal_d = dec_illegal;
               if (dec_is_jmp || (dec_is_jz && zero_flag)) pc_d = operand;
               else                                        pc_d = pc_inc;
            end
         end
         ST_WAIT_SW: begin
            if (sw_valid) begin
               bus_d    = dec_bus;
               ld_d     = dec_ld;
               sw_ack_d = 1'b1;
               pc_d     = pc_inc;
               state_d  = ST_FETCH;
            end
         end
         ST_HALTED: ;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         bus_q     <= BUS_NONE;
         alu_q     <= ALU_ADD;
         ld_q      <= '0;
         sw_ack_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         bus_q     <= bus_d;
         alu_q     <= alu_d;
         ld_q      <= ld_d;
         sw_ack_q  <= sw_ack_d;
         illegal_q <= illegal_d;
      end
   end

   assign imem_addr    = pc_q;
   assign pc           = pc_q;
   assign bus_selector = bus_q;
   assign alu_op       = alu_q;
   assign ld_a         = ld_q.a;
   assign ld_b         = ld_q.b;
   assign ld_rout      = ld_q.rout;
   assign ld_out       = ld_q.out;
   assign sw_ack       = sw_ack_q;
   assign illegal_op   = illegal_q;
   assign halted       = (state_q == ST_HALTED);

endmodule

// File: tb/tb_cpu_control_unit.sv
// -----------------------------------------------------------------------------
// tb_cpu_control_unit
// Bench for cpu_control_unit with a synchronous 16-entry ROM model. Every
// non-idle output cycle (bus != 111 or any strobe/ack/illegal) is matched
// against a queue of expected events tagged with the cycle they must appear.
// -----------------------------------------------------------------------------
module tb_cpu_control_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       run = 1'b0;
   logic [3:0] imem_addr;
   logic [7:0] imem_data = 8'h00;
   logic       sw_valid = 1'b0;
   logic       sw_ack;
   logic       zero_flag = 1'b0;
   logic [2:0] bus_selector;
   logic [1:0] alu_op;
   logic       ld_a, ld_b, ld_rout, ld_out;
   logic [3:0] pc;
   logic       halted;
   logic       illegal_op;

   logic [7:0]  rom [16];
   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;

   typedef struct {
      int unsigned cyc;
      logic [2:0]  bus;
      logic [1:0]  alu;
      logic [3:0]  ld;
      logic        ack;
      logic        ill;
   } ev_t;
   ev_t sb[$];

   typedef struct {
      logic [7:0] instr;
      logic       zf;
      logic       act;
      logic [2:0] bus;
      logic [1:0] alu;
      logic [3:0] ld;
      logic       ill;
      logic [3:0] pc_after;
   } vec_t;

   cpu_control_unit #(.PC_WIDTH(4), .RESET_PC(4'd0)) dut (
      .clk          (clk),
      .rst          (rst),
      .run          (run),
      .imem_addr    (imem_addr),
      .imem_data    (imem_data),
      .sw_valid     (sw_valid),
      .sw_ack       (sw_ack),
      .zero_flag    (zero_flag),
      .bus_selector (bus_selector),
      .alu_op       (alu_op),
      .ld_a         (ld_a),
      .ld_b         (ld_b),
      .ld_rout      (ld_rout),
      .ld_out       (ld_out),
      .pc           (pc),
      .halted       (halted),
      .illegal_op   (illegal_op)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc       <= cyc + 1;
      imem_data <= rom[imem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Output monitor / scoreboard consumer.
   always @(negedge clk) begin : monitor
      ev_t        e;
      logic [3:0] ldv;
      logic       active;
      ldv    = {ld_a, ld_b, ld_rout, ld_out};
      active = (bus_selector != 3'b111) || (ldv != 4'b0) || sw_ack || illegal_op;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         e = sb.pop_front();
         chk("missing_event_cycle", cyc, e.cyc);
      end
      if (active) begin
         if (sb.size() == 0) begin
            chk("unexpected_strobe", {bus_selector, ldv, sw_ack, illegal_op}, {3'b111, 4'b0, 1'b0, 1'b0});
         end else begin
            e = sb.pop_front();
            chk("event_cycle", cyc, e.cyc);
            chk("event_bus", bus_selector, e.bus);
            chk("event_ld", ldv, e.ld);
            chk("event_ack", sw_ack, e.ack);
            chk("event_ill", illegal_op, e.ill);
            if (e.ld[1]) chk("event_alu", alu_op, e.alu);
         end
      end
   end

   task automatic push(input int unsigned c, input logic [2:0] b, input logic [1:0] a,
                       input logic [3:0] l, input logic k, input logic i);
      ev_t e;
      e.cyc = c; e.bus = b; e.alu = a; e.ld = l; e.ack = k; e.ill = i;
      sb.push_back(e);
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 16; i++) rom[i] = 8'h00;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; run = 1'b0; sw_valid = 1'b0; zero_flag = 1'b0;
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_until(input int unsigned n);
      while (cyc < n) @(negedge clk);
   endtask

   // Start execution; returns the cycle count at the negedge run was raised.
   task automatic start(output int unsigned base);
      @(negedge clk);
      run  = 1'b1;
      base = cyc;
      @(negedge clk);
      run  = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : test
      vec_t        vt[11];
      int unsigned base;

      vt[0]  = '{8'h00, 1'b0, 1'b0, 3'b111, 2'b00, 4'b0000, 1'b0, 4'd1};
      vt[1]  = '{8'h30, 1'b0, 1'b1, 3'b111, 2'b00, 4'b0010, 1'b0, 4'd1};
      vt[2]  = '{8'h80, 1'b0, 1'b1, 3'b111, 2'b01, 4'b0010, 1'b0, 4'd1};
      vt[3]  = '{8'h40, 1'b0, 1'b1, 3'b011, 2'b00, 4'b0001, 1'b0, 4'd1};
      vt[4]  = '{8'h50, 1'b0, 1'b1, 3'b011, 2'b00, 4'b1000, 1'b0, 4'd1};
      vt[5]  = '{8'h60, 1'b0, 1'b1, 3'b101, 2'b00, 4'b1000, 1'b0, 4'd1};
      vt[6]  = '{8'h75, 1'b0, 1'b0, 3'b111, 2'b00, 4'b0000, 1'b0, 4'd5};
      vt[7]  = '{8'h9A, 1'b1, 1'b0, 3'b111, 2'b00, 4'b0000, 1'b0, 4'd10};
      vt[8]  = '{8'h9A, 1'b0, 1'b0, 3'b111, 2'b00, 4'b0000, 1'b0, 4'd1};
      vt[9]  = '{8'hB0, 1'b0, 1'b1, 3'b111, 2'b00, 4'b0000, 1'b1, 4'd1};
      vt[10] = '{8'hC3, 1'b0, 1'b1, 3'b111, 2'b00, 4'b0000, 1'b1, 4'd1};

      clear_rom();

      // Reset then idle with run low.
      do_reset();
      repeat (10) @(negedge clk);
      #1;
      chk("idle_pc", pc, 4'd0);
      chk("idle_imem_addr", imem_addr, 4'd0);
      chk("idle_bus", bus_selector, 3'b111);
      chk("idle_ld", {ld_a, ld_b, ld_rout, ld_out}, 4'b0);
      chk("idle_ack_ill", {sw_ack, illegal_op}, 2'b0);
      chk("idle_halted", halted, 1'b0);

      // Single-instruction vectors.
      for (int i = 0; i < 11; i++) begin
         do_reset();
         clear_rom();
         rom[0]    = vt[i].instr;
         zero_flag = vt[i].zf;
         start(base);
         if (vt[i].act) push(base + 4, vt[i].bus, vt[i].alu, vt[i].ld, 1'b0, vt[i].ill);
         wait_until(base + 4);
         #1;
         chk($sformatf("vec%0d_pc", i), pc, vt[i].pc_after);
         repeat (6) @(negedge clk);
         #1;
         chk($sformatf("vec%0d_pending", i), sb.size(), 0);
      end

      // IN_A with a delayed switch.
      do_reset();
      clear_rom();
      rom[0] = 8'h10;
      start(base);
      wait_until(base + 9);
      #1;
      chk("in_a_wait_pc", pc, 4'd0);
      sw_valid = 1'b1;
      push(base + 10, 3'b000, 2'b00, 4'b1000, 1'b1, 1'b0);
      wait_until(base + 10);
      #1;
      sw_valid = 1'b0;
      chk("in_a_pc_after", pc, 4'd1);
      repeat (4) @(negedge clk);
      #1;
      chk("in_a_pending", sb.size(), 0);

      // IN_B with switch already valid on entry.
      do_reset();
      clear_rom();
      rom[0]   = 8'h20;
      sw_valid = 1'b1;
      start(base);
      push(base + 5, 3'b000, 2'b00, 4'b0100, 1'b1, 1'b0);
      wait_until(base + 5);
      #1;
      sw_valid = 1'b0;
      chk("in_b_pc_after", pc, 4'd1);
      repeat (3) @(negedge clk);
      #1;
      chk("in_b_pending", sb.size(), 0);

      // LDC3_A, ADD, OUT back to back.
      do_reset();
      clear_rom();
      rom[0] = 8'h60; rom[1] = 8'h30; rom[2] = 8'h40;
      start(base);
      push(base + 4,  3'b101, 2'b00, 4'b1000, 1'b0, 1'b0);
      push(base + 7,  3'b111, 2'b00, 4'b0010, 1'b0, 1'b0);
      push(base + 10, 3'b011, 2'b00, 4'b0001, 1'b0, 1'b0);
      wait_until(base + 12);
      #1;
      chk("seq_pc", pc, 4'd3);
      chk("seq_pending", sb.size(), 0);

      // Jump to slot 15, undefined opcode there, pc wraps.
      do_reset();
      clear_rom();
      rom[0] = 8'h7F; rom[15] = 8'hB0;
      start(base);
      push(base + 7, 3'b111, 2'b00, 4'b0000, 1'b0, 1'b1);
      wait_until(base + 4);
      #1;
      chk("wrap_jmp_pc", pc, 4'd15);
      wait_until(base + 7);
      #1;
      chk("wrap_pc", pc, 4'd0);
      @(negedge clk);
      #1;
      chk("wrap_ill_single", illegal_op, 1'b0);
      chk("wrap_pending", sb.size(), 0);

      // Halt: outputs frozen, run ignored.
      do_reset();
      clear_rom();
      rom[2] = 8'hF0;
      start(base);
      wait_until(base + 9);
      #1;
      chk("hlt_not_yet", halted, 1'b0);
      wait_until(base + 10);
      #1;
      chk("hlt_halted", halted, 1'b1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         run = ~run;
         #1;
         chk($sformatf("hlt_hold%0d", i), {halted, pc}, {1'b1, 4'd2});
      end
      run = 1'b0;

      // Async reset while waiting on the switch, switch valid at that edge.
      do_reset();
      clear_rom();
      rom[3] = 8'h10;
      start(base);
      wait_until(base + 15);
      #1;
      chk("midwait_pc_before", pc, 4'd3);
      sw_valid = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk("midwait_pc_async", pc, 4'd0);
      chk("midwait_outs_async", {bus_selector, ld_a, sw_ack, halted}, {3'b111, 3'b000});
      @(negedge clk);
      #1;
      chk("midwait_no_ack", {sw_ack, ld_a, ld_b}, 3'b000);
      rst      = 1'b0;
      sw_valid = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      chk("midwait_idle_pc", pc, 4'd0);
      chk("midwait_pending", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
